// File: rtl/mulaw_enc_arbiter.sv
// mulaw_enc_arbiter: round-robin arbitrated, serial chord-search mu-law encoder
// One sample in flight; code returned with requester id on a valid/ready output.
module mulaw_enc_arbiter #(
  parameter int P_NUM_REQ    = 4,
  parameter int P_DECODED_DW = 14,
  parameter int P_ENCODED_DW = 8,
  parameter int P_NUM_CHORD  = 8,
  parameter int P_INVERT     = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [P_NUM_REQ-1:0]                req_valid,
  output logic [P_NUM_REQ-1:0]                req_ready,
  input  logic [P_NUM_REQ*P_DECODED_DW-1:0]   req_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [P_ENCODED_DW-1:0]             out_code,
  output logic [$clog2(P_NUM_REQ)-1:0]        out_id,
  output logic                                out_clip,
  output logic                                busy
);
  localparam int DW   = P_DECODED_DW;
  localparam int CW   = $clog2(P_NUM_CHORD);
  localparam int M    = P_ENCODED_DW - 1 - CW;
  localparam int TOP  = M + P_NUM_CHORD + 1;
  localparam int BIAS = 2**(M+1) + 1;
  localparam int CLIP = 2**TOP - BIAS - 1;
  localparam int IW   = $clog2(P_NUM_REQ);

  if (TOP > DW - 1) begin : g_bad_cfg
    $error("mulaw_enc_arbiter: chord range exceeds sample width");
  end

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t                  r_state;
  logic [IW-1:0]           r_ptr;
  logic [CW-1:0]           r_cnt;
  logic [TOP-2:0]          r_half;
  logic                    r_neg;
  logic [IW-1:0]           r_id;
  logic                    r_clip;
  logic                    r_valid;
  logic [P_ENCODED_DW-1:0] r_code;

  logic                    w_gv;
  logic [IW-1:0]           w_grant;
  logic [DW-1:0]           w_sample;
  logic [DW:0]             w_mag;
  logic                    w_clip;
  logic [TOP-2:0]          w_half;
  logic                    w_hit;
  logic [M-1:0]            w_mant;
  logic [P_ENCODED_DW-1:0] w_raw;

  // descending scan so the smallest cyclic offset from r_ptr wins
  always_comb begin
    w_gv    = 1'b0;
    w_grant = '0;
    for (int i = P_NUM_REQ - 1; i >= 0; i--)
      if (req_valid[(int'(r_ptr) + i) % P_NUM_REQ]) begin
        w_gv    = 1'b1;
        w_grant = IW'((int'(r_ptr) + i) % P_NUM_REQ);
      end
  end

  assign w_sample = req_data[int'(w_grant)*DW +: DW];
  assign w_mag    = w_sample[DW-1] ? -{w_sample[DW-1], w_sample} : {1'b0, w_sample};
  assign w_clip   = w_mag > (DW+1)'(CLIP);
  // holds biased>>1 directly: BIAS is odd, and biased[0] never reaches the code
  assign w_half   = w_clip ? '1 : w_mag[TOP-1:1] + (TOP-1)'(2**M) + (TOP-1)'(w_mag[0]);

  always_comb begin
    w_hit  = 1'b0;
    w_mant = '0;
    for (int i = 0; i < P_NUM_CHORD; i++)
      if (r_cnt == CW'(i)) begin
        w_hit  = r_half[i+M] | (i == 0);
        w_mant = r_half[i +: M];
      end
  end

  assign w_raw     = {r_neg, r_cnt, w_mant};
  assign req_ready = (r_state == IDLE && w_gv) ? P_NUM_REQ'(1) << w_grant : '0;
  assign out_valid = r_valid;
  assign out_code  = r_code;
  assign out_id    = r_id;
  assign out_clip  = r_clip;
  assign busy      = r_state != IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_half  <= '0;
      r_neg   <= 1'b0;
      r_id    <= '0;
      r_clip  <= 1'b0;
      r_valid <= 1'b0;
      r_code  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_gv) begin
          r_half  <= w_half;
          r_neg   <= w_sample[DW-1];
          r_clip  <= w_clip;
          r_id    <= w_grant;
          r_ptr   <= (int'(w_grant) == P_NUM_REQ - 1) ? '0 : w_grant + 1'b1;
          r_cnt   <= CW'(P_NUM_CHORD - 1);
          r_state <= SEARCH;
        end
        SEARCH: if (w_hit) begin
          r_code  <= (P_INVERT != 0) ? ~w_raw : w_raw;
          r_valid <= 1'b1;
          r_state <= DONE;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
        DONE: if (out_ready) begin
          r_valid <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mulaw_enc_arbiter.sv
// tb_mulaw_enc_arbiter: table vectors, corner sequences and randomized
// round-robin traffic checked against an arithmetic G.711 model.
module tb_mulaw_enc_arbiter;
  localparam int N  = 4;
  localparam int DW = 14;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [7:0]      out_code;
  logic [1:0]      out_id;
  logic            out_clip;
  logic            busy;

  mulaw_enc_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_id(out_id), .out_clip(out_clip), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] g_code;
  logic [1:0] g_id;
  logic       g_clip;
  logic [3:0] g_rdy;
  int         g_lat;
  int         g_wait;

  typedef struct {
    logic [3:0] mask;
    int         sample;
    int         id;
    logic [7:0] code;
    logic       clip;
    int         lat;
  } row_t;

  row_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, exp);
    end
  endtask

  // G.711 mu-law from the rules: saturate, bias, chord = position of top set bit
  function automatic logic [11:0] ref_enc(input int s);
    int mag, b, ch;
    logic c;
    logic [7:0] raw;
    mag = s < 0 ? -s : s;
    c = mag > 8158;
    if (c) mag = 8158;
    b = mag + 33;
    ch = 0;
    for (int k = 1; k < 8; k++) if (b >= (32 << k)) ch = k;
    raw = {s < 0, 3'(ch), 4'((b >> (ch + 1)) & 15)};
    return {3'(ch), c, ~raw};
  endfunction

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // offer mask, complete one transaction with out_ready high
  task automatic run(input logic [3:0] mask);
    int n;
    @(negedge clk);
    req_valid = mask;
    n = 0;
    #1;
    while (req_ready == '0 && n < 50) begin @(negedge clk); #1; n++; end
    g_wait = n;
    g_rdy  = req_ready;
    @(posedge clk);
    #1 req_valid = '0;
    n = 1;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    g_lat  = n;
    g_code = out_code;
    g_id   = out_id;
    g_clip = out_clip;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0]   e;
    logic [DW-1:0] d[N];
    int            rr_val[N];
    int            cnt, cyc, seen, ptr, eid;
    logic [3:0]    mask;

    tbl[0]  = '{4'b0001,     0, 0, 8'hFF, 1'b0, 9};
    tbl[1]  = '{4'b0010,  8158, 1, 8'h80, 1'b0, 2};
    tbl[2]  = '{4'b0010, -8192, 1, 8'h00, 1'b1, 2};
    tbl[3]  = '{4'b0100,  1000, 2, 8'hAF, 1'b0, 4};
    tbl[4]  = '{4'b1000, -1000, 3, 8'h2F, 1'b0, 4};
    tbl[5]  = '{4'b0001,    33, 0, 8'hEF, 1'b0, 8};
    tbl[6]  = '{4'b0010,    -1, 1, 8'h7E, 1'b0, 9};
    tbl[7]  = '{4'b0100,  8159, 2, 8'h80, 1'b1, 2};
    tbl[8]  = '{4'b1000,  8191, 3, 8'h80, 1'b1, 2};
    tbl[9]  = '{4'b0001, -8158, 0, 8'h00, 1'b0, 2};
    tbl[10] = '{4'b0010,   -33, 1, 8'h6F, 1'b0, 8};

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_code", out_code, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_out_clip", out_clip, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int r = 0; r < 11; r++) begin
      req_data = '0;
      req_data[tbl[r].id*DW +: DW] = DW'(tbl[r].sample);
      run(tbl[r].mask);
      chk("tbl_wait", g_wait, 0);
      chk("tbl_ready", g_rdy, tbl[r].mask);
      chk("tbl_code", g_code, tbl[r].code);
      chk("tbl_clip", g_clip, tbl[r].clip);
      chk("tbl_id", g_id, tbl[r].id);
      chk("tbl_latency", g_lat, tbl[r].lat);
    end

    do_reset();
    for (int j = 0; j < N; j++) begin
      rr_val[j] = j * 2000 - 3000;
      req_data[j*DW +: DW] = DW'(rr_val[j]);
    end
    @(negedge clk) req_valid = 4'hF;
    cnt = 0;
    cyc = 0;
    while (cnt < 8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        chk("rr_id", out_id, cnt % N);
        e = ref_enc(rr_val[cnt % N]);
        chk("rr_code", out_code, e[7:0]);
        cnt++;
        if (cnt == 8) req_valid = '0;
      end
    end
    chk("rr_count", cnt, 8);
    req_valid = '0;

    run(4'b0100);
    chk("solo_wait", g_wait, 0);
    chk("solo_ready", g_rdy, 4'b0100);
    chk("solo_id", g_id, 2);

    out_ready = 1'b0;
    req_data[1*DW +: DW] = DW'(5000);
    e = ref_enc(5000);
    @(negedge clk) req_valid = 4'b0010;
    @(posedge clk);
    #1 req_valid = '0;
    cnt = 0;
    while (!out_valid && cnt < 40) begin @(posedge clk); #1; cnt++; end
    chk("bp_valid_rise", out_valid, 1);
    @(negedge clk) req_valid = 4'b1101;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_code", out_code, e[7:0]);
      chk("bp_hold_ready", req_ready, 0);
      chk("bp_hold_busy", busy, 1);
    end
    chk("bp_hold_id", out_id, 1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", out_valid, 0);
    @(negedge clk);
    #1;
    chk("bp_next_grant", req_ready, 4'b0100);
    req_valid = '0;

    req_data[0 +: DW] = '0;
    @(negedge clk) req_valid = 4'b0001;
    @(posedge clk);
    #1 req_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_code", out_code, 0);
    chk("abort_out_id", out_id, 0);
    chk("abort_out_clip", out_clip, 0);
    chk("abort_busy", busy, 0);
    chk("abort_req_ready", req_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    repeat (20) begin @(negedge clk); if (out_valid) seen++; end
    chk("abort_no_output", seen, 0);
    req_data[3*DW +: DW] = DW'(-1000);
    run(4'b1000);
    chk("post_abort_ready", g_rdy, 4'b1000);
    chk("post_abort_id", g_id, 3);
    chk("post_abort_code", g_code, 8'h2F);
    chk("post_abort_latency", g_lat, 4);

    do_reset();
    ptr = 0;
    for (int t = 0; t < 300; t++) begin
      mask = 4'($urandom_range(1, 15));
      for (int j = 0; j < N; j++) begin
        d[j] = DW'($urandom);
        req_data[j*DW +: DW] = d[j];
      end
      eid = -1;
      for (int k = 0; k < N; k++)
        if (eid < 0 && mask[(ptr + k) % N]) eid = (ptr + k) % N;
      ptr = (eid + 1) % N;
      e = ref_enc(int'($signed(d[eid])));
      run(mask);
      chk("rnd_ready", g_rdy, 4'b0001 << eid);
      chk("rnd_id", g_id, eid);
      chk("rnd_code", g_code, e[7:0]);
      chk("rnd_clip", g_clip, e[8]);
      chk("rnd_latency", g_lat, 9 - int'(e[11:9]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
